mem_bus_arbiter: RTL and testbench

//  Shares one Wishbone-style memory master port between a core's instruction-fetch port and data port.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_timeout.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the single-memory bus arbiter: FSM state encoding,
// port identifiers and the round-robin winner selection.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_t;

  // Round-robin pick: a lone requester wins outright; on a conflict the
  // port that did not win last time gets the bus.
  function automatic port_t pick_winner(input logic  imem_req,
                                        input logic  dmem_req,
                                        input port_t last_grant);
    if (imem_req && dmem_req) begin
      return (last_grant == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
    end else if (dmem_req) begin
      return PORT_DMEM;
    end else begin
      return PORT_IMEM;
    end
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Bus-cycle watchdog for the arbiter. Counts cycles spent in BUS and flags
// expiry on the TIMEOUT_CYCLES-th cycle. Only instantiated when the
// arbiter is built with ARB_TIMEOUT_EN.
module mem_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,    // grant issued this cycle, BUS starts next cycle
  input  logic active,   // FSM is in BUS
  output logic expired   // this is the last BUS cycle allowed
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] count;

  // Counter is zero in the first BUS cycle and advances once per BUS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active) begin
      count <= count + 1'b1;
    end
  end

  assign expired = active && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style master port between a core's instruction-fetch
// and data ports. Round-robin arbitration, one outstanding transfer, all
// bus outputs registered. FSM: IDLE -> BUS -> RESP -> IDLE.
// Optional feature macro: ARB_TIMEOUT_EN adds a bus watchdog that aborts a
// transfer after TIMEOUT_CYCLES cycles without ack and reports it on err.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction fetch port
  input  logic                    imem_req_i,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  output logic                    imem_gnt_o,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  output logic                    imem_err_o,
  // data port
  input  logic                    dmem_req_i,
  input  logic                    dmem_we_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  output logic                    dmem_gnt_o,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    dmem_err_o,
  // shared bus master
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_t state;
  port_t      last_grant;
  port_t      owner;
  port_t      winner;

  logic                  cyc_q;
  logic                  we_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  imem_gnt_q;
  logic                  dmem_gnt_q;
  logic [DATA_WIDTH-1:0] imem_rdata_q;
  logic [DATA_WIDTH-1:0] dmem_rdata_q;

  logic grant_now;  // IDLE with at least one request: start a transfer
  logic in_bus;
  logic bus_done;   // acked in BUS: normal completion
  logic abort;      // watchdog expiry without ack
  logic finish;     // leave BUS this cycle

  assign winner    = pick_winner(imem_req_i, dmem_req_i, last_grant);
  assign grant_now = (state == ARB_IDLE) && (imem_req_i || dmem_req_i);
  assign in_bus    = (state == ARB_BUS);
  assign bus_done  = in_bus && wb_ack_i;
  assign finish    = bus_done || abort;

`ifdef ARB_TIMEOUT_EN
  logic expired;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (grant_now),
    .active  (in_bus),
    .expired (expired)
  );

  // An ack in the expiry cycle takes priority over the abort.
  assign abort = expired && !wb_ack_i;
`else
  assign abort = 1'b0;
`endif

  // FSM, arbitration history and the bus cycle strobe.
  // NOTE: every clocked register is assigned with <= so all of them update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_IMEM;
      owner      <= PORT_IMEM;
      cyc_q      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_now) begin
            owner      <= winner;
            last_grant <= winner;
            cyc_q      <= 1'b1;
            state      <= ARB_BUS;
          end
        end
        ARB_BUS: begin
          if (finish) begin
            cyc_q <= 1'b0;
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          cyc_q <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Latch the winner's request fields; they stay constant through BUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_now) begin
      if (winner == PORT_IMEM) begin
        we_q    <= 1'b0;
        wstrb_q <= '1;
        addr_q  <= imem_addr_i;
        wdata_q <= '0;
      end else begin
        we_q    <= dmem_we_i;
        wstrb_q <= dmem_we_i ? dmem_wstrb_i : {STRB_WIDTH{1'b1}};
        addr_q  <= dmem_addr_i;
        wdata_q <= dmem_wdata_i;
      end
    end
  end

  // Response side: one-cycle grant pulse to the owner and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_gnt_q   <= 1'b0;
      dmem_gnt_q   <= 1'b0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else begin
      imem_gnt_q <= 1'b0;
      dmem_gnt_q <= 1'b0;
      if (finish) begin
        if (owner == PORT_IMEM) begin
          imem_gnt_q   <= 1'b1;
          imem_rdata_q <= abort ? '0 : wb_data_i;
        end else begin
          dmem_gnt_q <= 1'b1;
          if (abort) begin
            dmem_rdata_q <= '0;
          end else if (!we_q) begin
            dmem_rdata_q <= wb_data_i;
          end
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic imem_err_q;
  logic dmem_err_q;

  // Error flags accompany the grant pulse of an aborted transfer only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_err_q <= 1'b0;
      dmem_err_q <= 1'b0;
    end else begin
      imem_err_q <= abort && (owner == PORT_IMEM);
      dmem_err_q <= abort && (owner == PORT_DMEM);
    end
  end

  assign imem_err_o = imem_err_q;
  assign dmem_err_o = dmem_err_q;
`else
  assign imem_err_o = 1'b0;
  assign dmem_err_o = 1'b0;
`endif

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_wstrb_o   = wstrb_q;
  assign wb_addr_o    = addr_q;
  assign wb_data_o    = wdata_q;

  assign imem_gnt_o   = imem_gnt_q;
  assign dmem_gnt_o   = dmem_gnt_q;
  assign imem_rdata_o = imem_rdata_q;
  assign dmem_rdata_o = dmem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Stimulus pushes the expected
// grant response into a queue; a negedge monitor pops and compares every
// time a gnt appears. Bus-side fields are checked directly while cyc is up.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req_i = 1'b0;
  logic [AW-1:0] imem_addr_i = '0;
  logic          imem_gnt_o;
  logic [DW-1:0] imem_rdata_o;
  logic          imem_err_o;
  logic          dmem_req_i = 1'b0;
  logic          dmem_we_i = 1'b0;
  logic [SW-1:0] dmem_wstrb_i = '0;
  logic [AW-1:0] dmem_addr_i = '0;
  logic [DW-1:0] dmem_wdata_i = '0;
  logic          dmem_gnt_o;
  logic [DW-1:0] dmem_rdata_o;
  logic          dmem_err_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [SW-1:0] wb_wstrb_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [DW-1:0] wb_data_i = '0;
  logic          wb_ack_i = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_i   (imem_req_i),
    .imem_addr_i  (imem_addr_i),
    .imem_gnt_o   (imem_gnt_o),
    .imem_rdata_o (imem_rdata_o),
    .imem_err_o   (imem_err_o),
    .dmem_req_i   (dmem_req_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_wstrb_i (dmem_wstrb_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_gnt_o   (dmem_gnt_o),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_err_o   (dmem_err_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_wstrb_o   (wb_wstrb_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_data_i    (wb_data_i),
    .wb_ack_i     (wb_ack_i)
  );

  typedef struct {
    port_t         port;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every gnt must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (imem_gnt_o || dmem_gnt_o) begin
      check("gnt_exclusive", {62'd0, imem_gnt_o, dmem_gnt_o} & 64'h3, imem_gnt_o ? 64'h2 : 64'h1);
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", {62'd0, imem_gnt_o, dmem_gnt_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("gnt_port", {63'd0, dmem_gnt_o}, {63'd0, e.port == PORT_DMEM});
        check("gnt_rdata", (e.port == PORT_IMEM) ? imem_rdata_o : dmem_rdata_o, e.rdata);
        check("gnt_err", (e.port == PORT_IMEM) ? imem_err_o : dmem_err_o, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the bus cycle to start; ends in the first BUS cycle.
  task automatic wait_cyc(input string name);
    int n = 0;
    while (!wb_cyc_o && n < 50) begin
      tick();
      n++;
    end
    check({name, "_cyc_start"}, wb_cyc_o, 1);
  endtask

  // Hold off for 'waits' BUS cycles, then ack once; returns in the RESP cycle.
  task automatic ack_after(input int waits, input logic [DW-1:0] data);
    repeat (waits) tick();
    wb_ack_i  = 1'b1;
    wb_data_i = data;
    tick();
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cyc"},   wb_cyc_o, 0);
    check({tag, "_stb"},   wb_stb_o, 0);
    check({tag, "_bus"},   {wb_we_o, wb_wstrb_o, wb_addr_o, wb_data_o}, 0);
    check({tag, "_gnt"},   {imem_gnt_o, dmem_gnt_o, imem_err_o, dmem_err_o}, 0);
    check({tag, "_rdata"}, {imem_rdata_o, dmem_rdata_o}, 0);
  endtask

  logic [DW-1:0] model_dmem_rdata;
  logic [DW-1:0] model_imem_rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    port_t         p;
    logic [DW-1:0] d;
    int            n;

    repeat (3) tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // Both ports request continuously: D,I,D,I,D,I after reset.
    imem_addr_i = 32'h40;
    dmem_addr_i = 32'h80;
    dmem_we_i   = 1'b0;
    imem_req_i  = 1'b1;
    dmem_req_i  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p = (k % 2 == 0) ? PORT_DMEM : PORT_IMEM;
      d = 32'hA000_0000 + DW'(k);
      exp_q.push_back('{p, d, 1'b0});
      wait_cyc("rr");
      check("rr_addr", wb_addr_o, (p == PORT_DMEM) ? 64'h80 : 64'h40);
      check("rr_we", wb_we_o, 0);
      ack_after(1, d);
      if (k == 5) begin
        imem_req_i = 1'b0;
        dmem_req_i = 1'b0;
      end
      check("rr_cyc_drop", wb_cyc_o, 0);
    end
    model_dmem_rdata = 32'hA000_0004;
    model_imem_rdata = 32'hA000_0005;
    repeat (2) tick();

    // Fetch only, two wait states.
    imem_addr_i = 32'h100;
    imem_req_i  = 1'b1;
    exp_q.push_back('{PORT_IMEM, 32'h0000_0013, 1'b0});
    tick();
    check("fetch_latency", wb_cyc_o, 1);
    check("fetch_addr", wb_addr_o, 32'h100);
    check("fetch_we", wb_we_o, 0);
    check("fetch_wstrb", wb_wstrb_o, 4'hF);
    check("fetch_stb", wb_stb_o, 1);
    ack_after(2, 32'h0000_0013);
    imem_req_i = 1'b0;
    check("fetch_gnt_latency", imem_gnt_o, 1);
    tick();
    check("fetch_gnt_one_cycle", imem_gnt_o, 0);
    model_imem_rdata = 32'h13;
    repeat (2) tick();

    // Data write, immediate ack; read data must not change.
    dmem_we_i    = 1'b1;
    dmem_addr_i  = 32'h2004;
    dmem_wstrb_i = 4'b0011;
    dmem_wdata_i = 32'hDEAD_BEEF;
    dmem_req_i   = 1'b1;
    exp_q.push_back('{PORT_DMEM, model_dmem_rdata, 1'b0});
    wait_cyc("write");
    check("write_bus", {wb_we_o, wb_wstrb_o, wb_addr_o, wb_data_o},
          {1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF});
    ack_after(0, 32'h5555_5555);
    dmem_req_i = 1'b0;
    dmem_we_i  = 1'b0;
    check("write_gnt", dmem_gnt_o, 1);
    tick();
    check("write_gnt_one_cycle", dmem_gnt_o, 0);
    check("write_rdata_kept", dmem_rdata_o, model_dmem_rdata);
    repeat (2) tick();

    // Spurious ack while idle.
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h77;
    repeat (2) tick();
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
    check("idle_ack_cyc", wb_cyc_o, 0);
    check("idle_ack_rdata", imem_rdata_o, model_imem_rdata);

    // Ack held into RESP: the second ack must be ignored.
    dmem_addr_i = 32'h3000;
    dmem_req_i  = 1'b1;
    exp_q.push_back('{PORT_DMEM, 32'h0000_1234, 1'b0});
    wait_cyc("resp_ack");
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h1234;
    tick();
    dmem_req_i = 1'b0;
    wb_data_i  = 32'h0BAD;
    tick();
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
    check("resp_ack_cyc", wb_cyc_o, 0);
    check("resp_ack_rdata", dmem_rdata_o, 32'h1234);
    tick();
    check("resp_ack_cyc_later", wb_cyc_o, 0);
    repeat (2) tick();

    // Reset in the middle of a bus cycle.
    dmem_addr_i = 32'h4000;
    dmem_req_i  = 1'b1;
    wait_cyc("rst_mid");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", wb_cyc_o, 0);
    check("rst_mid_gnt", {imem_gnt_o, dmem_gnt_o}, 0);
    dmem_req_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check_reset_state("rst_mid");
    tick();
    imem_addr_i = 32'h200;
    imem_req_i  = 1'b1;
    exp_q.push_back('{PORT_IMEM, 32'h0000_CAFE, 1'b0});
    wait_cyc("post_rst");
    check("post_rst_addr", wb_addr_o, 32'h200);
    ack_after(1, 32'h0000_CAFE);
    imem_req_i = 1'b0;
    repeat (3) tick();

`ifdef ARB_TIMEOUT_EN
    // No ack: abort after 8 BUS cycles with err and zero data.
    imem_addr_i = 32'h300;
    imem_req_i  = 1'b1;
    exp_q.push_back('{PORT_IMEM, 32'h0, 1'b1});
    wait_cyc("timeout");
    n = 0;
    while (wb_cyc_o && n < 20) begin
      n++;
      tick();
    end
    imem_req_i = 1'b0;
    check("timeout_bus_cycles", n, 8);
    check("timeout_err", {imem_gnt_o, imem_err_o}, 2'b11);
    repeat (3) tick();

    // Ack arrives in the expiry cycle: normal completion.
    imem_req_i = 1'b1;
    exp_q.push_back('{PORT_IMEM, 32'h0000_0ACE, 1'b0});
    wait_cyc("timeout_ack");
    ack_after(7, 32'h0000_0ACE);
    imem_req_i = 1'b0;
    check("timeout_ack_err", {imem_gnt_o, imem_err_o}, 2'b10);
    repeat (3) tick();
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
